sr_latch_checker: RTL and testbench

- Clocked response checker for the gated SR latch; the receiving end of the latch's S/R/En stimulus protocol.
- Samples the latch inputs (en, s, r) and outputs (q, qbar) each clock and runs a cycle-accurate reference model of the latch state.
- Flags mismatches and counts set, reset, hold and invalid events.
- Sits beside the latch in self-checking benches and in on-chip BIST wrappers.

---
 rtl/sr_latch_checker.sv | 164 ++++++++++++++++
 tb/tb_sr_latch_checker.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/sr_latch_checker.sv
// Response checker for a gated SR latch: runs a reference model of the latch state,
// compares q/qbar once {en,s,r} has been stable for SETTLE cycles, and counts events.
module sr_latch_checker #(
    parameter int CNT_W  = 8,
    parameter int SETTLE = 2    // legal range 1..15
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             s,
    input  logic             r,
    input  logic             q,
    input  logic             qbar,
    input  logic             chk_en,
    input  logic             clr_cnt,
    output logic [1:0]       model_state,
    output logic             err,
    output logic [1:0]       err_code,
    output logic             err_sticky,
    output logic [CNT_W-1:0] set_cnt,
    output logic [CNT_W-1:0] reset_cnt,
    output logic [CNT_W-1:0] hold_cnt,
    output logic [CNT_W-1:0] invalid_cnt,
    output logic [CNT_W-1:0] mismatch_cnt
);

    typedef enum logic [1:0] {
        ST_UNKNOWN = 2'b00,
        ST_ZERO    = 2'b01,
        ST_ONE     = 2'b10,
        ST_INVALID = 2'b11
    } state_e;

    localparam logic [1:0] CODE_VALUE = 2'b01;
    localparam logic [1:0] CODE_COMPL = 2'b10;
    localparam logic [1:0] CODE_INV   = 2'b11;
    localparam logic [3:0] SETTLE_C   = 4'(SETTLE);

    localparam int IDX_SET = 0;
    localparam int IDX_RST = 1;
    localparam int IDX_HLD = 2;
    localparam int IDX_INV = 3;
    localparam int IDX_MIS = 4;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [2:0]       in_q;
    logic             change;
    logic [3:0]       stab_q, stab_d;
    logic             cmp_active;
    state_e           state_q, state_d;
    logic             mis;
    logic [1:0]       mis_code;
    logic             err_q, err_d;
    logic [1:0]       err_code_q;
    logic             err_sticky_q;
    logic [4:0]       inc;
    logic [CNT_W-1:0] cnt_q [5];

    assign change = ({en, s, r} != in_q);

    // Comparison looks at the count including this sample, so the edge that
    // carries an input change is never compared against the stale model state.
    always_comb begin
        if (change)                stab_d = '0;
        else if (stab_q == SETTLE_C) stab_d = stab_q;
        else                       stab_d = stab_q + 4'd1;
    end

    assign cmp_active = chk_en && (stab_d == SETTLE_C);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_q    <= 3'b000;
            stab_q  <= '0;
            state_q <= ST_UNKNOWN;
        end else begin
            in_q    <= {en, s, r};
            stab_q  <= stab_d;
            state_q <= state_d;
        end
    end

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        if (en) begin
            unique case ({s, r})
                2'b10: state_d = ST_ONE;
                2'b01: state_d = ST_ZERO;
                2'b11: state_d = ST_INVALID;
                2'b00: if (state_q == ST_INVALID) state_d = ST_UNKNOWN;
            endcase
        end
    end

    always_comb begin
        model_state = state_q;
        mis         = 1'b0;
        mis_code    = 2'b00;
        unique case (state_q)
            ST_ZERO: begin
                if (q)          begin mis = 1'b1; mis_code = CODE_VALUE; end
                else if (!qbar) begin mis = 1'b1; mis_code = CODE_COMPL; end
            end
            ST_ONE: begin
                if (!q)         begin mis = 1'b1; mis_code = CODE_VALUE; end
                else if (qbar)  begin mis = 1'b1; mis_code = CODE_COMPL; end
            end
            ST_INVALID: if (q != qbar) begin mis = 1'b1; mis_code = CODE_INV; end
            ST_UNKNOWN: if (q == qbar) begin mis = 1'b1; mis_code = CODE_COMPL; end
        endcase
    end

    assign err_d = cmp_active && mis;

    always_comb begin
        inc          = '0;
        inc[IDX_SET] = change && en &&  s && !r;
        inc[IDX_RST] = change && en && !s &&  r;
        inc[IDX_HLD] = change && en && !s && !r;
        inc[IDX_INV] = change && en &&  s &&  r;
        inc[IDX_MIS] = err_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
        end else begin
            err_q <= err_d;
            if (err_d) err_code_q <= mis_code;
        end
    end

    // Clear wins over any same-cycle increment or error.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_sticky_q <= 1'b0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else if (clr_cnt) begin
            err_sticky_q <= 1'b0;
            for (int i = 0; i < 5; i++) cnt_q[i] <= '0;
        end else begin
            if (err_d) err_sticky_q <= 1'b1;
            for (int i = 0; i < 5; i++) begin
                if (inc[i]) cnt_q[i] <= sat_inc(cnt_q[i]);
            end
        end
    end

    assign err          = err_q;
    assign err_code     = err_code_q;
    assign err_sticky   = err_sticky_q;
    assign set_cnt      = cnt_q[IDX_SET];
    assign reset_cnt    = cnt_q[IDX_RST];
    assign hold_cnt     = cnt_q[IDX_HLD];
    assign invalid_cnt  = cnt_q[IDX_INV];
    assign mismatch_cnt = cnt_q[IDX_MIS];

endmodule

// File: tb/tb_sr_latch_checker.sv
// Bench for sr_latch_checker: two instances (8-bit and 2-bit counters) share directed
// stimulus and are checked every cycle against an event-level model, plus literal checks.
module tb_sr_latch_checker;

    localparam int SETTLE = 2;
    localparam logic [1:0] M_UNK  = 2'b00;
    localparam logic [1:0] M_ZERO = 2'b01;
    localparam logic [1:0] M_ONE  = 2'b10;
    localparam logic [1:0] M_INV  = 2'b11;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic en = 1'b0, s = 1'b0, r = 1'b0, q = 1'b0, qbar = 1'b0;
    logic chk_en = 1'b1, clr_cnt = 1'b0;

    logic [1:0] ms_a, code_a, ms_b, code_b;
    logic       err_a, sticky_a, err_b, sticky_b;
    logic [7:0] set_a, rst_a, hold_a, inv_a, mis_a;
    logic [1:0] set_b, rst_b, hold_b, inv_b, mis_b;

    int n_checks = 0;
    int n_fail   = 0;
    int n_pulse  = 0;
    int p0;

    // Model: cycle index of the last input change, unsaturated event totals.
    int         cyc = 0, last_chg = 0;
    logic [2:0] prev = 3'b000;
    logic [1:0] m_state = M_UNK;
    int         n_set = 0, n_rst = 0, n_hold = 0, n_inv = 0, n_mis = 0;
    logic       e_err = 1'b0, e_sticky = 1'b0;
    logic [1:0] e_code = 2'b00;

    always #5 clk = ~clk;

    sr_latch_checker #(.CNT_W(8), .SETTLE(SETTLE)) u_a (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .chk_en(chk_en), .clr_cnt(clr_cnt), .model_state(ms_a), .err(err_a),
        .err_code(code_a), .err_sticky(sticky_a), .set_cnt(set_a), .reset_cnt(rst_a),
        .hold_cnt(hold_a), .invalid_cnt(inv_a), .mismatch_cnt(mis_a)
    );

    sr_latch_checker #(.CNT_W(2), .SETTLE(SETTLE)) u_b (
        .clk(clk), .rst(rst), .en(en), .s(s), .r(r), .q(q), .qbar(qbar),
        .chk_en(chk_en), .clr_cnt(clr_cnt), .model_state(ms_b), .err(err_b),
        .err_code(code_b), .err_sticky(sticky_b), .set_cnt(set_b), .reset_cnt(rst_b),
        .hold_cnt(hold_b), .invalid_cnt(inv_b), .mismatch_cnt(mis_b)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int satv(input int n, input int w);
        int mx;
        mx = (1 << w) - 1;
        return (n > mx) ? mx : n;
    endfunction

    task automatic model_reset();
        cyc = 0; last_chg = 0; prev = 3'b000; m_state = M_UNK;
        n_set = 0; n_rst = 0; n_hold = 0; n_inv = 0; n_mis = 0;
        e_err = 1'b0; e_sticky = 1'b0; e_code = 2'b00;
    endtask

    task automatic model_edge();
        logic [2:0] cur;
        logic       chg, active, bad, want_q;
        logic [1:0] code;
        cur = {en, s, r};
        chg = (cur != prev);
        cyc++;
        active = chk_en && !chg && (cyc - last_chg >= SETTLE);
        bad = 1'b0;
        code = 2'b00;
        if (m_state == M_ZERO || m_state == M_ONE) begin
            want_q = (m_state == M_ONE);
            if (q != want_q)          begin bad = 1'b1; code = 2'b01; end
            else if (qbar != !want_q) begin bad = 1'b1; code = 2'b10; end
        end else if (m_state == M_INV) begin
            if (q != qbar) begin bad = 1'b1; code = 2'b11; end
        end else begin
            if (q == qbar) begin bad = 1'b1; code = 2'b10; end
        end
        e_err = active && bad;
        if (e_err) begin e_code = code; e_sticky = 1'b1; n_mis++; end
        if (chg) begin
            last_chg = cyc;
            if (en) begin
                if (s && !r) n_set++;
                else if (!s && r) n_rst++;
                else if (s && r) n_inv++;
                else n_hold++;
            end
        end
        if (en) begin
            if (s && !r) m_state = M_ONE;
            else if (!s && r) m_state = M_ZERO;
            else if (s && r) m_state = M_INV;
            else if (m_state == M_INV) m_state = M_UNK;
        end
        prev = cur;
        if (clr_cnt) begin
            n_set = 0; n_rst = 0; n_hold = 0; n_inv = 0; n_mis = 0;
            e_sticky = 1'b0;
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) model_reset();
            else model_edge();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (err_a === 1'b1) n_pulse++;
            check("a.model_state", ms_a, m_state);
            check("a.err", err_a, e_err);
            check("a.err_code", code_a, e_code);
            check("a.err_sticky", sticky_a, e_sticky);
            check("a.set_cnt", set_a, satv(n_set, 8));
            check("a.reset_cnt", rst_a, satv(n_rst, 8));
            check("a.hold_cnt", hold_a, satv(n_hold, 8));
            check("a.invalid_cnt", inv_a, satv(n_inv, 8));
            check("a.mismatch_cnt", mis_a, satv(n_mis, 8));
            check("b.model_state", ms_b, m_state);
            check("b.err", err_b, e_err);
            check("b.err_code", code_b, e_code);
            check("b.err_sticky", sticky_b, e_sticky);
            check("b.set_cnt", set_b, satv(n_set, 2));
            check("b.reset_cnt", rst_b, satv(n_rst, 2));
            check("b.hold_cnt", hold_b, satv(n_hold, 2));
            check("b.invalid_cnt", inv_b, satv(n_inv, 2));
            check("b.mismatch_cnt", mis_b, satv(n_mis, 2));
        end
    end

    task automatic drive(input logic e, input logic si, input logic ri, input logic qi, input logic qbi);
        en = e; s = si; r = ri; q = qi; qbar = qbi;
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #2;
        check("reset model_state", ms_a, 2'b00);
        check("reset set_cnt", set_a, 8'd0);
        check("reset err", err_a, 1'b0);
        rst = 1'b0;

        // Disabled latch: no events, model stays UNKNOWN.
        p0 = n_pulse;
        drive(0, 0, 1, 0, 1);
        tick(4);
        check("idle model_state", ms_a, 2'b00);
        check("idle reset_cnt", rst_a, 8'd0);
        check("idle err pulses", n_pulse - p0, 0);

        // Reset, hold, set with a correctly behaving latch.
        drive(1, 0, 1, 0, 1); tick(5);
        drive(1, 0, 0, 0, 1); tick(5);
        drive(1, 1, 0, 1, 0); tick(5);
        check("seq reset_cnt", rst_a, 8'd1);
        check("seq hold_cnt", hold_a, 8'd1);
        check("seq set_cnt", set_a, 8'd1);
        check("seq model_state", ms_a, 2'b10);
        check("seq mismatch_cnt", mis_a, 8'd0);

        // Wrong q while settled in ONE.
        p0 = n_pulse;
        drive(1, 1, 0, 0, 1); tick(3);
        drive(1, 1, 0, 1, 0); tick(1);
        check("value err pulses", n_pulse - p0, 3);
        check("value err_code", code_a, 2'b01);
        check("value mismatch_cnt", mis_a, 8'd3);
        check("value err_sticky", sticky_a, 1'b1);

        // Invalid then release to UNKNOWN.
        p0 = n_pulse;
        drive(1, 1, 1, 0, 0); tick(5);
        check("inv invalid_cnt", inv_a, 8'd1);
        drive(1, 0, 0, 1, 0); tick(5);
        check("inv model_state", ms_a, 2'b00);
        check("inv err pulses", n_pulse - p0, 0);

        // chk_en=0 masks errors; re-enabling exposes a complement error.
        p0 = n_pulse;
        chk_en = 1'b0;
        drive(1, 0, 0, 1, 1); tick(4);
        check("masked err pulses", n_pulse - p0, 0);
        chk_en = 1'b1;
        tick(2);
        drive(1, 0, 0, 1, 0); tick(1);
        check("unknown err pulses", n_pulse - p0, 2);
        check("unknown err_code", code_a, 2'b10);
        check("unknown mismatch_cnt", mis_a, 8'd5);

        // Toggling s never settles, so a wrong q is never flagged.
        p0 = n_pulse;
        for (int i = 0; i < 8; i++) begin
            drive(1, (i % 2) == 0, 0, 0, 1);
            tick(1);
        end
        drive(1, 1, 0, 1, 0); tick(4);
        check("toggle err pulses", n_pulse - p0, 0);

        // Alternations saturate the 2-bit counters.
        for (int i = 0; i < 5; i++) begin
            drive(1, 0, 1, 0, 1); tick(3);
            drive(1, 1, 0, 1, 0); tick(3);
        end
        check("sat a.set_cnt", set_a, 8'd11);
        check("sat a.reset_cnt", rst_a, 8'd6);
        check("sat b.set_cnt", set_b, 2'd3);
        check("sat b.reset_cnt", rst_b, 2'd3);
        check("sat b.hold_cnt", hold_b, 2'd3);
        check("sat b.mismatch_cnt", mis_b, 2'd3);

        clr_cnt = 1'b1; tick(1); clr_cnt = 1'b0;
        check("clr b.set_cnt", set_b, 2'd0);
        check("clr b.mismatch_cnt", mis_b, 2'd0);
        check("clr a.hold_cnt", hold_a, 8'd0);
        check("clr err_sticky", sticky_a, 1'b0);
        check("clr keeps err_code", code_a, 2'b10);
        check("clr keeps model_state", ms_a, 2'b10);

        // Asynchronous reset while err is high.
        drive(1, 0, 1, 0, 1); tick(3);
        drive(1, 0, 1, 1, 0); tick(1);
        check("pre-rst err", err_a, 1'b1);
        #1 rst = 1'b1;
        #1;
        check("async model_state", ms_a, 2'b00);
        check("async err", err_a, 1'b0);
        check("async err_code", code_a, 2'b00);
        check("async err_sticky", sticky_a, 1'b0);
        check("async reset_cnt", rst_a, 8'd0);
        check("async mismatch_cnt", mis_a, 8'd0);
        tick(2);
        rst = 1'b0;
        drive(0, 0, 0, 0, 1);
        tick(5);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
